mc_controller: RTL and testbench

//  Multicycle MIPS control FSM sequencing the shared datapath (3-port regfile, unified instr/data mem, ALU, PC).

---
 rtl/mc_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_mc_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences PC/IR/regfile/memory enables and datapath mux selects.
// Optional BNE support is enabled by defining MC_BNE_EN; outputs are decoded from the current state.
module mc_controller #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       pcwrite_en,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic [3:0] state_o,
   output logic       timeout
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BEQ    = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_BNE    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

   state_t     state_q, state_d;
   logic [7:0] wait_cnt_q;
   logic       timeout_q;
   logic       mem_state;
   logic       mem_wait;
   logic       branch;
   logic [2:0] funct_alu;

   assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   assign mem_wait  = mem_state && !mem_ready;

   always_comb begin
      funct_alu = ALU_ADD;
      case (funct)
         FN_ADD:  funct_alu = ALU_ADD;
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_SLT:  funct_alu = ALU_SLT;
         default: funct_alu = ALU_ADD;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BEQ;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
`ifdef MC_BNE_EN
               OP_BNE:       state_d = S_BNE;
`endif
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW)      state_d = S_MEMRD;
            else if (op == OP_SW) state_d = S_MEMWR;
            else                  state_d = S_FETCH;
         end
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BEQ:    state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   // The wait counter restarts on every state change, so it only measures the current access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= 8'd0;
         timeout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            wait_cnt_q <= 8'd0;
         else if (mem_wait && (wait_cnt_q != 8'hFF))
            wait_cnt_q <= wait_cnt_q + 8'd1;
         if (mem_wait && (wait_cnt_q == WAIT_MAX))
            timeout_q <= 1'b1;
      end
   end

   always_comb begin
      pcwrite    = 1'b0;
      branch     = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b000;
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               alusrcb    = 2'b01;
               alucontrol = ALU_ADD;
               irwrite    = mem_ready;
               pcwrite    = mem_ready;
            end
            S_DECODE: begin
               alusrcb    = 2'b11;
               alucontrol = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
               alusrca    = 1'b1;
               alusrcb    = 2'b10;
               alucontrol = ALU_ADD;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
               regwrite = 1'b1;
               memtoreg = 1'b1;
            end
            S_MEMWR: begin
               iord     = 1'b1;
               memwrite = 1'b1;
            end
            S_EXEC: begin
               alusrca    = 1'b1;
               alucontrol = funct_alu;
            end
            S_ALUWB: begin
               regwrite = 1'b1;
               regdst   = 1'b1;
            end
            S_BEQ: begin
               alusrca    = 1'b1;
               alucontrol = ALU_SUB;
               pcsrc      = 2'b01;
               branch     = zero;
            end
`ifdef MC_BNE_EN
            S_BNE: begin
               alusrca    = 1'b1;
               alucontrol = ALU_SUB;
               pcsrc      = 2'b01;
               branch     = ~zero;
            end
`endif
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
               pcsrc   = 2'b10;
               pcwrite = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign pcwrite_en = pcwrite | branch;
   assign state_o    = state_q;
   assign timeout    = timeout_q;

   always_ff @(posedge clk) begin
      if (rst_n) assert (!(regwrite && memwrite));
   end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: one task per scenario, inline checks, one summary line.
module tb_mc_controller;

   logic       clk;
   logic       rst_n;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pcwrite, pcwrite_en, memwrite, irwrite, regwrite;
   logic       iord, memtoreg, regdst, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state_o;
   logic       timeout;
   logic [4:0] en;
   logic [9:0] sel;

   int errors = 0;
   int checks = 0;

   mc_controller #(.MEM_WAIT_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .pcwrite_en(pcwrite_en), .memwrite(memwrite), .irwrite(irwrite),
      .regwrite(regwrite), .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state_o(state_o), .timeout(timeout)
   );

   assign en  = {pcwrite, pcwrite_en, memwrite, irwrite, regwrite};
   assign sel = {iord, memtoreg, regdst, alusrca, alusrcb, pcsrc, alucontrol[2:1]};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic next_cyc;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      next_cyc();
      checks++;
      if ({state_o, timeout} !== {4'd0, 1'b0}) begin
         errors++; $display("FAIL reset_state: got state=%0d timeout=%b exp state=0 timeout=0", state_o, timeout);
      end
      checks++;
      if ({en, sel, alucontrol[0]} !== 16'd0) begin
         errors++; $display("FAIL reset_outputs: got en=%b sel=%b exp all zero", en, sel);
      end
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_rtype;
      int rw_cycles = 0;
      op = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
      checks++;
      if ({state_o, en, alusrcb, alucontrol} !== {4'd0, 5'b11010, 2'b01, 3'b010}) begin
         errors++; $display("FAIL rtype_fetch: got st=%0d en=%b b=%b alu=%b exp st=0 en=11010 b=01 alu=010", state_o, en, alusrcb, alucontrol);
      end
      next_cyc();
      checks++;
      if ({state_o, en, alusrcb} !== {4'd1, 5'b00000, 2'b11}) begin
         errors++; $display("FAIL rtype_decode: got st=%0d en=%b b=%b exp st=1 en=0 b=11", state_o, en, alusrcb);
      end
      next_cyc();
      if (regwrite) rw_cycles++;
      checks++;
      if ({state_o, alusrca, alusrcb, alucontrol, regwrite} !== {4'd6, 1'b1, 2'b00, 3'b010, 1'b0}) begin
         errors++; $display("FAIL rtype_exec: got st=%0d a=%b b=%b alu=%b rw=%b exp st=6 a=1 b=00 alu=010 rw=0", state_o, alusrca, alusrcb, alucontrol, regwrite);
      end
      next_cyc();
      if (regwrite) rw_cycles++;
      checks++;
      if ({state_o, regwrite, regdst, memtoreg, memwrite} !== {4'd7, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         errors++; $display("FAIL rtype_aluwb: got st=%0d rw=%b rd=%b m2r=%b mw=%b exp st=7 1 1 0 0", state_o, regwrite, regdst, memtoreg, memwrite);
      end
      next_cyc();
      checks++;
      if ({state_o, rw_cycles[3:0]} !== {4'd0, 4'd1}) begin
         errors++; $display("FAIL rtype_return: got st=%0d regwrite_cycles=%0d exp st=0 regwrite_cycles=1", state_o, rw_cycles);
      end
   endtask

   task automatic test_funct;
      logic [5:0] fn [5] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
      logic [2:0] ac [5] = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
      op = 6'b000000; mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         funct = fn[i];
         next_cyc();
         next_cyc();
         checks++;
         if ({state_o, alucontrol} !== {4'd6, ac[i]}) begin
            errors++; $display("FAIL funct_%0d: got st=%0d alu=%b exp st=6 alu=%b", i, state_o, alucontrol, ac[i]);
         end
         next_cyc();
         next_cyc();
      end
   endtask

   task automatic test_lw_wait;
      int busy = 0;
      op = 6'b100011; mem_ready = 1'b1;
      next_cyc();
      busy++;
      next_cyc();
      busy++;
      checks++;
      if ({state_o, alusrca, alusrcb, alucontrol} !== {4'd2, 1'b1, 2'b10, 3'b010}) begin
         errors++; $display("FAIL lw_memadr: got st=%0d a=%b b=%b alu=%b exp st=2 a=1 b=10 alu=010", state_o, alusrca, alusrcb, alucontrol);
      end
      mem_ready = 1'b0;
      next_cyc();
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         #1;
         if (state_o != 4'd0) busy++;
         checks++;
         if ({state_o, iord, regwrite, memwrite} !== {4'd3, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL lw_memrd_%0d: got st=%0d iord=%b rw=%b mw=%b exp st=3 1 0 0", i, state_o, iord, regwrite, memwrite);
         end
         next_cyc();
      end
      if (state_o != 4'd0) busy++;
      checks++;
      if ({state_o, regwrite, memtoreg, regdst} !== {4'd4, 1'b1, 1'b1, 1'b0}) begin
         errors++; $display("FAIL lw_memwb: got st=%0d rw=%b m2r=%b rd=%b exp st=4 1 1 0", state_o, regwrite, memtoreg, regdst);
      end
      next_cyc();
      checks++;
      if ({state_o, 8'(busy + 1)} !== {4'd0, 8'd8}) begin
         errors++; $display("FAIL lw_total: got st=%0d cycles=%0d exp st=0 cycles=8", state_o, busy + 1);
      end
   endtask

   task automatic test_beq;
      logic [1:0] zv = 2'b10;
      op = 6'b000100; mem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         zero = zv[1-i];
         next_cyc();
         next_cyc();
         checks++;
         if ({state_o, pcwrite, pcwrite_en, pcsrc, alucontrol, alusrca, alusrcb} !==
             {4'd8, 1'b0, zv[1-i], 2'b01, 3'b110, 1'b1, 2'b00}) begin
            errors++; $display("FAIL beq_z%0d: got st=%0d pw=%b pwe=%b pcsrc=%b alu=%b exp st=8 pw=0 pwe=%b pcsrc=01 alu=110", zv[1-i], state_o, pcwrite, pcwrite_en, pcsrc, alucontrol, zv[1-i]);
         end
         next_cyc();
         checks++;
         if (state_o !== 4'd0) begin
            errors++; $display("FAIL beq_next_z%0d: got st=%0d exp st=0", zv[1-i], state_o);
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_jump_addi;
      op = 6'b000010; mem_ready = 1'b1;
      next_cyc();
      next_cyc();
      checks++;
      if ({state_o, pcwrite, pcwrite_en, pcsrc, regwrite, memwrite} !== {4'd11, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0}) begin
         errors++; $display("FAIL jump: got st=%0d pw=%b pwe=%b pcsrc=%b exp st=11 1 1 10", state_o, pcwrite, pcwrite_en, pcsrc);
      end
      next_cyc();
      op = 6'b001000;
      next_cyc();
      next_cyc();
      checks++;
      if ({state_o, alusrca, alusrcb, alucontrol} !== {4'd9, 1'b1, 2'b10, 3'b010}) begin
         errors++; $display("FAIL addi_ex: got st=%0d a=%b b=%b alu=%b exp st=9 1 10 010", state_o, alusrca, alusrcb, alucontrol);
      end
      next_cyc();
      checks++;
      if ({state_o, regwrite, regdst, memtoreg} !== {4'd10, 1'b1, 1'b0, 1'b0}) begin
         errors++; $display("FAIL addi_wb: got st=%0d rw=%b rd=%b m2r=%b exp st=10 1 0 0", state_o, regwrite, regdst, memtoreg);
      end
      next_cyc();
   endtask

   task automatic test_unknown_op;
      op = 6'b111111; mem_ready = 1'b0;
      next_cyc();
      checks++;
      if ({state_o, en} !== {4'd0, 5'b00000}) begin
         errors++; $display("FAIL fetch_hold: got st=%0d en=%b exp st=0 en=00000", state_o, en);
      end
      mem_ready = 1'b1;
      next_cyc();
      checks++;
      if ({state_o, en} !== {4'd1, 5'b00000}) begin
         errors++; $display("FAIL unknown_decode: got st=%0d en=%b exp st=1 en=00000", state_o, en);
      end
      next_cyc();
      checks++;
      if (state_o !== 4'd0) begin
         errors++; $display("FAIL unknown_next: got st=%0d exp st=0", state_o);
      end
   endtask

   task automatic test_sw_timeout;
      op = 6'b101011; mem_ready = 1'b1;
      checks++;
      if (timeout !== 1'b0) begin
         errors++; $display("FAIL sw_timeout_pre: got %b exp 0", timeout);
      end
      next_cyc();
      next_cyc();
      mem_ready = 1'b0;
      next_cyc();
      for (int i = 0; i < 7; i++) begin
         mem_ready = (i == 6);
         #1;
         checks++;
         if ({state_o, memwrite, iord, regwrite, timeout} !== {4'd5, 1'b1, 1'b1, 1'b0, (i >= 5)}) begin
            errors++; $display("FAIL sw_memwr_%0d: got st=%0d mw=%b iord=%b rw=%b to=%b exp st=5 1 1 0 to=%b", i, state_o, memwrite, iord, regwrite, timeout, (i >= 5));
         end
         next_cyc();
      end
      checks++;
      if ({state_o, memwrite, timeout} !== {4'd0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL sw_after: got st=%0d mw=%b to=%b exp st=0 mw=0 to=1", state_o, memwrite, timeout);
      end
   endtask

   task automatic test_bne;
      op = 6'b000101; zero = 1'b0; mem_ready = 1'b1;
      next_cyc();
      next_cyc();
`ifdef MC_BNE_EN
      checks++;
      if ({state_o, pcwrite, pcwrite_en, pcsrc, alucontrol} !== {4'd12, 1'b0, 1'b1, 2'b01, 3'b110}) begin
         errors++; $display("FAIL bne_taken: got st=%0d pw=%b pwe=%b pcsrc=%b alu=%b exp st=12 0 1 01 110", state_o, pcwrite, pcwrite_en, pcsrc, alucontrol);
      end
      next_cyc();
      checks++;
      if (state_o !== 4'd0) begin
         errors++; $display("FAIL bne_next: got st=%0d exp st=0", state_o);
      end
`else
      checks++;
      if ({state_o, en} !== {4'd0, 5'b11010}) begin
         errors++; $display("FAIL bne_disabled: got st=%0d en=%b exp st=0 en=11010", state_o, en);
      end
`endif
      checks++;
      if (timeout !== 1'b1) begin
         errors++; $display("FAIL timeout_sticky: got %b exp 1", timeout);
      end
   endtask

   task automatic test_reset_mid;
      op = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
      next_cyc();
      next_cyc();
      next_cyc();
      checks++;
      if ({state_o, regwrite} !== {4'd7, 1'b1}) begin
         errors++; $display("FAIL mid_pre: got st=%0d rw=%b exp st=7 rw=1", state_o, regwrite);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (en !== 5'b00000) begin
         errors++; $display("FAIL mid_reset_en: got en=%b exp 00000", en);
      end
      next_cyc();
      checks++;
      if ({state_o, timeout} !== {4'd0, 1'b0}) begin
         errors++; $display("FAIL mid_reset_state: got st=%0d to=%b exp st=0 to=0", state_o, timeout);
      end
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_funct();
      test_lw_wait();
      test_beq();
      test_jump_addi();
      test_unknown_op();
      test_sw_timeout();
      test_bne();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
